pose_score_accumulator: RTL and testbench

//  Query-side client of the distance-transform scorer. Takes a user skeleton

---
 rtl/pose_score_accumulator.sv | 176 +++++++++++++++++
 tb/tb_pose_score_accumulator.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pose_score_accumulator.sv
// Pose score accumulator: queues the skeleton pixels of a user frame, asks the
// distance-transform scorer for each one and sums the clipped distances.
module pose_score_accumulator #(
  parameter  int HRES       = 320,
  parameter  int VRES       = 180,
  parameter  int MAX_DIST   = 64,
  parameter  int FIFO_DEPTH = 64,
  parameter  int TIMEOUT    = 8,
  parameter  int SUM_WIDTH  = 24,
  localparam int HWIDTH     = $clog2(HRES),
  localparam int VWIDTH     = $clog2(VRES),
  localparam int DWIDTH     = $clog2(HRES + VRES + 1),
  localparam int CWIDTH     = $clog2(HRES * VRES + 1)
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 frame_start_in,
  input  logic                 frame_end_in,
  input  logic [HWIDTH-1:0]    pixel_hcount_in,
  input  logic [VWIDTH-1:0]    pixel_vcount_in,
  input  logic                 pixel_in,
  input  logic                 pixel_valid_in,
  output logic [HWIDTH-1:0]    query_hcount_out,
  output logic [VWIDTH-1:0]    query_vcount_out,
  output logic                 query_valid_out,
  input  logic [HWIDTH-1:0]    resp_hcount_in,
  input  logic [VWIDTH-1:0]    resp_vcount_in,
  input  logic [DWIDTH-1:0]    resp_distance_in,
  input  logic                 resp_valid_in,
  output logic [SUM_WIDTH-1:0] sum_out,
  output logic [CWIDTH-1:0]    count_out,
  output logic                 score_valid_out,
  output logic                 overflow_out,
  output logic [15:0]          retry_count_out
);

  localparam int AWIDTH = $clog2(FIFO_DEPTH);
  localparam int FWIDTH = AWIDTH + 1;
  localparam int TWIDTH = $clog2(TIMEOUT + 1);
  localparam int EWIDTH = HWIDTH + VWIDTH;
  localparam int SWIDE  = SUM_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t state, next_state;

  logic [EWIDTH-1:0] mem [FIFO_DEPTH];
  logic [AWIDTH-1:0] wr_ptr, rd_ptr;
  logic [FWIDTH-1:0] fill;
  logic [TWIDTH-1:0] wait_cnt;
  logic              end_pending;

  logic              fifo_empty, fifo_full;
  logic              push, pop, drop;
  logic              match, timeout;
  logic [HWIDTH-1:0] head_h;
  logic [VWIDTH-1:0] head_v;
  logic [DWIDTH-1:0] dist_clip;
  logic [SWIDE-1:0]  sum_wide;

  assign fifo_empty = (fill == '0);
  assign fifo_full  = (fill == FWIDTH'(FIFO_DEPTH));
  assign {head_h, head_v} = mem[rd_ptr];

  // Anything whose coordinates differ from the outstanding query is stale.
  assign match   = (state == ST_WAIT) && resp_valid_in &&
                   (resp_hcount_in == query_hcount_out) &&
                   (resp_vcount_in == query_vcount_out);
  assign timeout = (state == ST_WAIT) && !match &&
                   (wait_cnt == TWIDTH'(TIMEOUT - 1));

  assign pop  = match;
  // A full queue still takes a pixel in the cycle its head is retired.
  assign push = pixel_valid_in && pixel_in && (!fifo_full || pop);
  assign drop = pixel_valid_in && pixel_in && fifo_full && !pop;

  assign dist_clip = (resp_distance_in > DWIDTH'(MAX_DIST)) ? DWIDTH'(MAX_DIST)
                                                            : resp_distance_in;
  assign sum_wide  = {1'b0, sum_out} + SWIDE'(dist_clip);

  assign query_valid_out = (state == ST_ISSUE);
  assign score_valid_out = (state == ST_DONE);

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty)      next_state = ST_ISSUE;
        else if (end_pending) next_state = ST_DONE;
      end
      ST_ISSUE: next_state = ST_WAIT;
      ST_WAIT: begin
        if (match)        next_state = (fill > FWIDTH'(1)) ? ST_ISSUE : ST_IDLE;
        else if (timeout) next_state = ST_ISSUE;
      end
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // NOTE: queue storage is not reset; the pointers and fill level decide
  // which entries are live, so old contents are never observed.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= {pixel_hcount_in, pixel_vcount_in};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state            <= ST_IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fill             <= '0;
      wait_cnt         <= '0;
      end_pending      <= 1'b0;
      query_hcount_out <= '0;
      query_vcount_out <= '0;
      sum_out          <= '0;
      count_out        <= '0;
      overflow_out     <= 1'b0;
      retry_count_out  <= '0;
    end else if (frame_start_in) begin
      state           <= ST_IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fill            <= '0;
      wait_cnt        <= '0;
      end_pending     <= 1'b0;
      sum_out         <= '0;
      count_out       <= '0;
      overflow_out    <= 1'b0;
      retry_count_out <= '0;
    end else begin
      state <= next_state;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase

      if (drop) overflow_out <= 1'b1;

      // A new frame_end in the DONE cycle re-arms for the following frame.
      if (state == ST_DONE) end_pending <= 1'b0;
      if (frame_end_in)     end_pending <= 1'b1;

      if (state == ST_ISSUE) begin
        query_hcount_out <= head_h;
        query_vcount_out <= head_v;
        wait_cnt         <= '0;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (match) begin
        sum_out <= sum_wide[SUM_WIDTH] ? '1 : sum_wide[SUM_WIDTH-1:0];
        if (count_out != '1) count_out <= count_out + 1'b1;
      end

      if (timeout && (retry_count_out != '1))
        retry_count_out <= retry_count_out + 1'b1;
    end
  end

endmodule

// File: tb/tb_pose_score_accumulator.sv
// Directed bench for pose_score_accumulator with a 3-cycle scorer model that
// can be silenced or made to emit an injected stale response.
module tb_pose_score_accumulator;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        frame_start_in = 1'b0;
  logic        frame_end_in = 1'b0;
  logic [8:0]  pixel_hcount_in = '0;
  logic [7:0]  pixel_vcount_in = '0;
  logic        pixel_in = 1'b0;
  logic        pixel_valid_in = 1'b0;
  logic [8:0]  query_hcount_out;
  logic [7:0]  query_vcount_out;
  logic        query_valid_out;
  logic [8:0]  resp_hcount_in;
  logic [7:0]  resp_vcount_in;
  logic [8:0]  resp_distance_in;
  logic        resp_valid_in;
  logic [23:0] sum_out;
  logic [15:0] count_out;
  logic        score_valid_out;
  logic        overflow_out;
  logic [15:0] retry_count_out;

  int checks = 0;
  int errors = 0;

  // Scorer model controls: silent drops both captured queries and outputs.
  logic       silent = 1'b0;
  logic       inj_en = 1'b0;
  logic [8:0] inj_h = '0;
  logic [7:0] inj_v = '0;
  logic [8:0] inj_d = '0;

  logic [8:0] p1_h = '0, p2_h = '0, p3_h = '0;
  logic [7:0] p1_v = '0, p2_v = '0, p3_v = '0;
  logic       p1_ok = 1'b0, p2_ok = 1'b0, p3_ok = 1'b0;

  always #5 clk_in = ~clk_in;

  pose_score_accumulator dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .frame_start_in   (frame_start_in),
    .frame_end_in     (frame_end_in),
    .pixel_hcount_in  (pixel_hcount_in),
    .pixel_vcount_in  (pixel_vcount_in),
    .pixel_in         (pixel_in),
    .pixel_valid_in   (pixel_valid_in),
    .query_hcount_out (query_hcount_out),
    .query_vcount_out (query_vcount_out),
    .query_valid_out  (query_valid_out),
    .resp_hcount_in   (resp_hcount_in),
    .resp_vcount_in   (resp_vcount_in),
    .resp_distance_in (resp_distance_in),
    .resp_valid_in    (resp_valid_in),
    .sum_out          (sum_out),
    .count_out        (count_out),
    .score_valid_out  (score_valid_out),
    .overflow_out     (overflow_out),
    .retry_count_out  (retry_count_out)
  );

  function automatic logic [8:0] dist_of(input logic [8:0] h, input logic [7:0] v);
    if (h == 9'd10 && v == 8'd5) return 9'd7;
    if (h == 9'd11 && v == 8'd5) return 9'd200;
    return h;
  endfunction

  always @(posedge clk_in) begin
    p1_h <= query_hcount_out; p1_v <= query_vcount_out; p1_ok <= !silent;
    p2_h <= p1_h;             p2_v <= p1_v;             p2_ok <= p1_ok;
    p3_h <= p2_h;             p3_v <= p2_v;             p3_ok <= p2_ok;
  end

  assign resp_hcount_in   = inj_en ? inj_h : p3_h;
  assign resp_vcount_in   = inj_en ? inj_v : p3_v;
  assign resp_distance_in = inj_en ? inj_d : dist_of(p3_h, p3_v);
  assign resp_valid_in    = inj_en | (p3_ok & !silent);

  // Stimulus helpers; each is entered and left at a falling edge.
  task automatic drive_pixel(input int h, input int v, input bit last);
    pixel_hcount_in = 9'(h);
    pixel_vcount_in = 8'(v);
    pixel_in        = 1'b1;
    pixel_valid_in  = 1'b1;
    frame_end_in    = last;
    @(negedge clk_in);
    pixel_in       = 1'b0;
    pixel_valid_in = 1'b0;
    frame_end_in   = 1'b0;
  endtask

  task automatic pulse_start();
    frame_start_in = 1'b1;
    @(negedge clk_in);
    frame_start_in = 1'b0;
  endtask

  task automatic pulse_end();
    frame_end_in = 1'b1;
    @(negedge clk_in);
    frame_end_in = 1'b0;
  endtask

  task automatic wait_score(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_in);
      if (score_valid_out === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_query(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_in);
      if (query_valid_out === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic count_pulses(input int cycles, output int score_n, output int query_n);
    score_n = 0;
    query_n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_in);
      if (score_valid_out === 1'b1) score_n++;
      if (query_valid_out === 1'b1) query_n++;
    end
  endtask

  task automatic test_reset();
    int sn, qn;
    rst_n_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    checks++; if (sum_out !== 24'd0) begin errors++; $display("FAIL reset_sum: got %0d expected 0", sum_out); end
    checks++; if (count_out !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_out); end
    checks++; if (retry_count_out !== 16'd0) begin errors++; $display("FAIL reset_retry: got %0d expected 0", retry_count_out); end
    checks++; if ({score_valid_out, overflow_out, query_valid_out} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {score_valid_out, overflow_out, query_valid_out});
    end
    checks++; if ({query_hcount_out, query_vcount_out} !== 17'd0) begin
      errors++; $display("FAIL reset_query: got %0d/%0d expected 0/0", query_hcount_out, query_vcount_out);
    end
    count_pulses(20, sn, qn);
    checks++; if (qn !== 0) begin errors++; $display("FAIL reset_idle_query: got %0d pulses expected 0", qn); end
    checks++; if (sn !== 0) begin errors++; $display("FAIL reset_idle_score: got %0d pulses expected 0", sn); end
  endtask

  task automatic test_two_pixels();
    bit seen;
    int sn, qn;
    pulse_start();
    drive_pixel(10, 5, 1'b0);
    drive_pixel(11, 5, 1'b1);
    wait_score(60, seen);
    checks++; if (!seen) begin errors++; $display("FAIL two_done: got no score_valid expected pulse"); end
    checks++; if (sum_out !== 24'd71) begin errors++; $display("FAIL two_sum: got %0d expected 71", sum_out); end
    checks++; if (count_out !== 16'd2) begin errors++; $display("FAIL two_count: got %0d expected 2", count_out); end
    count_pulses(10, sn, qn);
    checks++; if (sn !== 0) begin errors++; $display("FAIL two_extra_pulse: got %0d expected 0", sn); end
    checks++; if (sum_out !== 24'd71) begin errors++; $display("FAIL two_sum_hold: got %0d expected 71", sum_out); end
  endtask

  task automatic test_timeout_retry();
    bit seen;
    pulse_start();
    drive_pixel(40, 9, 1'b1);
    repeat (3) @(negedge clk_in);
    silent = 1'b1;
    repeat (40) @(negedge clk_in);
    silent = 1'b0;
    wait_score(40, seen);
    checks++; if (!seen) begin errors++; $display("FAIL retry_done: got no score_valid expected pulse"); end
    checks++; if (retry_count_out !== 16'd5) begin errors++; $display("FAIL retry_count: got %0d expected 5", retry_count_out); end
    checks++; if (count_out !== 16'd1) begin errors++; $display("FAIL retry_once_count: got %0d expected 1", count_out); end
    checks++; if (sum_out !== 24'd40) begin errors++; $display("FAIL retry_once_sum: got %0d expected 40", sum_out); end
  endtask

  task automatic test_overflow();
    bit seen;
    silent = 1'b1;
    pulse_start();
    for (int i = 0; i < 70; i++) drive_pixel(i, 10, 1'b0);
    checks++; if (overflow_out !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow_out); end
    checks++; if (count_out !== 16'd0) begin errors++; $display("FAIL ovf_stalled_count: got %0d expected 0", count_out); end
    pulse_end();
    silent = 1'b0;
    wait_score(2000, seen);
    checks++; if (!seen) begin errors++; $display("FAIL ovf_done: got no score_valid expected pulse"); end
    checks++; if (count_out !== 16'd64) begin errors++; $display("FAIL ovf_count: got %0d expected 64", count_out); end
    checks++; if (sum_out !== 24'd2016) begin errors++; $display("FAIL ovf_sum: got %0d expected 2016", sum_out); end
    checks++; if (overflow_out !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow_out); end
  endtask

  task automatic test_stale_response();
    bit seen;
    silent = 1'b1;
    pulse_start();
    drive_pixel(4, 3, 1'b0);
    wait_query(10, seen);
    checks++; if (!seen) begin errors++; $display("FAIL stale_issue: got no query_valid expected pulse"); end
    @(negedge clk_in);
    @(negedge clk_in);
    inj_h = 9'd3; inj_v = 8'd3; inj_d = 9'd50; inj_en = 1'b1;
    repeat (2) @(negedge clk_in);
    inj_en = 1'b0;
    checks++; if (count_out !== 16'd0) begin errors++; $display("FAIL stale_ignored_count: got %0d expected 0", count_out); end
    checks++; if (sum_out !== 24'd0) begin errors++; $display("FAIL stale_ignored_sum: got %0d expected 0", sum_out); end
    silent = 1'b0;
    pulse_end();
    wait_score(40, seen);
    checks++; if (!seen) begin errors++; $display("FAIL stale_done: got no score_valid expected pulse"); end
    checks++; if (sum_out !== 24'd4) begin errors++; $display("FAIL stale_sum: got %0d expected 4", sum_out); end
    checks++; if (count_out !== 16'd1) begin errors++; $display("FAIL stale_count: got %0d expected 1", count_out); end
    checks++; if (retry_count_out !== 16'd0) begin errors++; $display("FAIL stale_retry: got %0d expected 0", retry_count_out); end
  endtask

  task automatic test_frame_abort();
    bit seen;
    int sn, qn;
    silent = 1'b0;
    pulse_start();
    drive_pixel(20, 7, 1'b0);
    repeat (10) @(negedge clk_in);
    checks++; if (sum_out !== 24'd20) begin errors++; $display("FAIL abort_pre_sum: got %0d expected 20", sum_out); end
    silent = 1'b1;
    for (int i = 0; i < 5; i++) drive_pixel(21 + i, 7, 1'b0);
    repeat (19) @(negedge clk_in);
    checks++; if (retry_count_out !== 16'd2) begin errors++; $display("FAIL abort_pre_retry: got %0d expected 2", retry_count_out); end
    pulse_start();
    checks++; if (sum_out !== 24'd0) begin errors++; $display("FAIL abort_sum: got %0d expected 0", sum_out); end
    checks++; if (count_out !== 16'd0) begin errors++; $display("FAIL abort_count: got %0d expected 0", count_out); end
    checks++; if (retry_count_out !== 16'd0) begin errors++; $display("FAIL abort_retry: got %0d expected 0", retry_count_out); end
    checks++; if (query_valid_out !== 1'b0) begin errors++; $display("FAIL abort_idle: got query_valid %b expected 0", query_valid_out); end
    silent = 1'b0;
    count_pulses(20, sn, qn);
    checks++; if (qn !== 0) begin errors++; $display("FAIL abort_flushed: got %0d queries expected 0", qn); end
    drive_pixel(30, 2, 1'b0);
    drive_pixel(31, 2, 1'b1);
    wait_score(60, seen);
    checks++; if (!seen) begin errors++; $display("FAIL abort_next_done: got no score_valid expected pulse"); end
    checks++; if (sum_out !== 24'd61) begin errors++; $display("FAIL abort_next_sum: got %0d expected 61", sum_out); end
    checks++; if (count_out !== 16'd2) begin errors++; $display("FAIL abort_next_count: got %0d expected 2", count_out); end
  endtask

  task automatic test_empty_frame();
    bit seen;
    int sn, qn;
    pulse_start();
    pulse_end();
    wait_score(3, seen);
    checks++; if (!seen) begin errors++; $display("FAIL empty_done: got no score_valid expected pulse"); end
    checks++; if (sum_out !== 24'd0) begin errors++; $display("FAIL empty_sum: got %0d expected 0", sum_out); end
    checks++; if (count_out !== 16'd0) begin errors++; $display("FAIL empty_count: got %0d expected 0", count_out); end
    count_pulses(5, sn, qn);
    checks++; if (sn !== 0) begin errors++; $display("FAIL empty_extra_pulse: got %0d expected 0", sn); end
  endtask

  initial begin
    @(negedge clk_in);
    test_reset();
    test_two_pixels();
    test_timeout_retry();
    test_overflow();
    test_stale_response();
    test_frame_abort();
    test_empty_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors so far", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
